// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// Optional memory-ready stalling is enabled with MC_CTRL_STALL_EN.
package mc_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_RST    = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_MEMADR = 4'd3;
    localparam state_t S_MEMRD  = 4'd4;
    localparam state_t S_MEMWB  = 4'd5;
    localparam state_t S_MEMWR  = 4'd6;
    localparam state_t S_EXEC   = 4'd7;
    localparam state_t S_ALUWB  = 4'd8;
    localparam state_t S_BRANCH = 4'd9;
    localparam state_t S_JUMP   = 4'd10;
    localparam state_t S_IMMEX  = 4'd11;
    localparam state_t S_IMMWB  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       ext_op;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || is_logic_imm(op) ||
               (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags in, control word out.
interface mc_ctrl_if;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       ExtOP;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Op, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        output MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOP,
        output ALUSrcB, ALUOp, PCSource, Illegal, State
    );

    modport slave (
        output Op, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        input  MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOP,
        input  ALUSrcB, ALUOp, PCSource, Illegal, State
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: state (+ IR opcode) -> datapath control word.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       ready,
    output ctrl_t      ctrl
);

    logic li;
    assign li = is_logic_imm(op);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                // PC and IR commit only on the cycle the memory delivers
                ctrl.ir_write  = ready;
                ctrl.pc_write  = ready;
                ctrl.alu_src_b = 2'b01;
                ctrl.pc_source = PCS_SEQ;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.ext_op    = li;
                ctrl.illegal   = ~is_legal(op);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_BR;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JMP;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = li ? ALU_LOGIC : ALU_ADD;
                ctrl.ext_op    = li;
            end
            S_IMMWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.ext_op    = li;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register and next-state logic.
// Define MC_CTRL_STALL_EN to hold FETCH/MEMRD/MEMWR until MemReady.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input logic      clk,
    input logic      rst_n,
    mc_ctrl_if.master bus
);

    state_t state, state_nxt;
    ctrl_t  ctrl;
    logic   ready;

`ifdef MC_CTRL_STALL_EN
    assign ready = bus.MemReady;
`else
    assign ready = 1'b1;
`endif

    // Zero goes straight to the datapath; it never steers the FSM
    logic unused_in;
    assign unused_in = ^{bus.Zero, bus.MemReady};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_RST:    state_nxt = S_FETCH;
            S_FETCH:  state_nxt = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (bus.Op)
                    OP_LW, OP_SW:           state_nxt = S_MEMADR;
                    OP_RTYPE:               state_nxt = S_EXEC;
                    OP_BEQ:                 state_nxt = S_BRANCH;
                    OP_J:                   state_nxt = S_JUMP;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:                 state_nxt = S_IMMEX;
                    default:                state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_IMMEX:  state_nxt = S_IMMWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state (state),
        .op    (bus.Op),
        .ready (ready),
        .ctrl  (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.ior_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ExtOP       = ctrl.ext_op;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.Illegal     = ctrl.illegal;
    assign bus.State       = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl against an instruction-level model.
// Per-cycle expectations are queued by the driver and checked by a monitor.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mc_ctrl_if bus();

    mc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MC_CTRL_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    localparam int RST = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4;
    localparam int MEMWB = 5, MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9;
    localparam int JUMP = 10, IMMEX = 11, IMMWB = 12;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ext;
        logic [1:0] asb, aop, pcs;
        logic ill;
    } exp_t;

    exp_t sb[$];
    int   prog[$];
    int   idx = 0;
    int   last_st = RST;
    logic [5:0] op = 6'd0;
    bit   force_en = 1'b0;
    logic [5:0] force_op = 6'd0;
    int   n_run = 0;
    int   n_fail = 0;

    function automatic exp_t model(input int s, input logic [5:0] o,
                                   input logic mr);
        exp_t e;
        bit li;
        bit ok;
        e = '0;
        li = (o == ANDI) || (o == ORI);
        ok = (o == LW) || (o == SW) || (o == RT) || (o == BEQ) ||
             (o == J) || (o == ADDI) || li;
        e.st = 4'(s);
        case (s)
            FETCH: begin
                e.mrd = 1; e.irw = mr || !STALL; e.pcw = mr || !STALL;
                e.asb = 2'b01;
            end
            DECODE: begin e.asb = 2'b11; e.ext = li; e.ill = !ok; end
            MEMADR: begin e.asa = 1; e.asb = 2'b10; end
            MEMRD:  begin e.mrd = 1; e.iord = 1; end
            MEMWB:  begin e.rw = 1; e.m2r = 1; end
            MEMWR:  begin e.mwr = 1; e.iord = 1; end
            EXEC:   begin e.asa = 1; e.aop = 2'b10; end
            ALUWB:  begin e.rw = 1; e.rdst = 1; end
            BRANCH: begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; end
            JUMP:   begin e.pcw = 1; e.pcs = 2'b10; end
            IMMEX:  begin
                e.asa = 1; e.asb = 2'b10; e.aop = li ? 2'b11 : 2'b00; e.ext = li;
            end
            IMMWB:  begin e.rw = 1; e.ext = li; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [5:0] pick();
        logic [5:0] tab [8] = '{LW, SW, RT, BEQ, J, ADDI, ANDI, ORI};
        if ($urandom_range(0, 4) == 0) return 6'($urandom);
        return tab[$urandom_range(0, 7)];
    endfunction

    task automatic new_instr(input logic [5:0] o);
        op = o;
        bus.Op = o;
        prog = {FETCH, DECODE};
        case (o)
            LW:               prog = {FETCH, DECODE, MEMADR, MEMRD, MEMWB};
            SW:               prog = {FETCH, DECODE, MEMADR, MEMWR};
            RT:               prog = {FETCH, DECODE, EXEC, ALUWB};
            BEQ:              prog = {FETCH, DECODE, BRANCH};
            J:                prog = {FETCH, DECODE, JUMP};
            ADDI, ANDI, ORI:  prog = {FETCH, DECODE, IMMEX, IMMWB};
            default:          prog = {FETCH, DECODE};
        endcase
        idx = 0;
    endtask

    task automatic step(input bit in_reset);
        logic mr;
        bit hold;
        @(negedge clk);
        #1;
        mr = 1'($urandom_range(0, 1));
        bus.MemReady = mr;
        bus.Zero = 1'($urandom_range(0, 1));
        if (in_reset) begin
            sb.push_back(model(RST, bus.Op, mr));
            last_st = RST;
            return;
        end
        if (idx >= prog.size()) new_instr(force_en ? force_op : pick());
        last_st = prog[idx];
        sb.push_back(model(prog[idx], op, mr));
        hold = STALL && !mr &&
               (prog[idx] == FETCH || prog[idx] == MEMRD || prog[idx] == MEMWR);
        if (!hold) idx++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step(1'b1);
        rst_n = 1'b1;
        prog.delete();
        idx = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {bus.State, bus.PCWrite, bus.PCWriteCond, bus.IorD,
                   bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                   bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ExtOP,
                   bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Illegal};
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL ctrl_word t=%0t op=%b got=%h (state %0d) exp=%h (state %0d)",
                         $time, bus.Op, got, got.st, e, e.st);
            end
        end
    end

    initial begin
        bit hit;
        bus.Op = 6'd0;
        bus.Zero = 1'b0;
        bus.MemReady = 1'b0;
        do_reset();
        repeat (600) step(1'b0);

        force_en = 1'b1;
        force_op = SW;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            step(1'b0);
            if (last_st == MEMWR) hit = 1'b1;
        end
        n_run++;
        if (!hit) begin
            n_fail++;
            $display("FAIL memwr_reach got=no_memwr exp=memwr_within_60_cycles");
        end else begin
            #2;
            rst_n = 1'b0;
            #1;
            n_run++;
            if (bus.MemWrite !== 1'b0 || bus.State !== 4'd0) begin
                n_fail++;
                $display("FAIL async_reset got MemWrite=%b State=%0d exp MemWrite=0 State=0",
                         bus.MemWrite, bus.State);
            end
        end
        force_en = 1'b0;
        do_reset();
        repeat (300) step(1'b0);

        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
